// File: rtl/lms_train_ctrl.sv
// lms_train_ctrl: sequences LMS training of a two-tap predictor (a*x + b*y).
// Define LMS_WEIGHT_SAT_EN to saturate weight sums instead of wrapping them.
module lms_train_ctrl #(
    parameter int DW       = 8,
    parameter int MU_SHIFT = 4,
    parameter int FW_LAT   = 1,
    parameter int MAX_ITER = 255,
    parameter int ERR_TOL  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] x_last,
    input  logic signed [DW-1:0] y_last,
    input  logic signed [DW-1:0] y_cur,
    output logic                 fw_en,
    input  logic signed [DW-1:0] fw_y_hat,
    output logic signed [DW-1:0] a_hat,
    output logic signed [DW-1:0] b_hat,
    output logic signed [DW-1:0] err,
    output logic [7:0]           iter,
    output logic                 busy,
    output logic                 done,
    output logic                 converged
);

    typedef enum logic [2:0] {IDLE, WAIT_S, FWD, ERR, UPD, DONE} state_t;

    localparam int CW = $clog2(FW_LAT + 2);
    localparam int PW = 2 * DW + 1;
    localparam int SW = PW + 1;

    localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [DW-1:0] x_q, x_d, yl_q, yl_d, yc_q, yc_d, yh_q, yh_d;
    logic signed [DW:0]   e_q, e_d;
    logic signed [DW-1:0] err_q, err_d, a_q, a_d, b_q, b_d;
    logic [7:0]           iter_q, iter_d;
    logic                 conv_q, conv_d;

    logic signed [DW:0]   e_full;
    logic signed [DW-1:0] e_sat;
    logic [DW:0]          e_abs;
    logic signed [PW-1:0] prod_a, prod_b;
    logic signed [SW-1:0] sum_a, sum_b;
    logic [7:0]           iter_inc;

    function automatic logic signed [DW-1:0] narrow(input logic signed [SW-1:0] s);
        logic signed [DW-1:0] r;
`ifdef LMS_WEIGHT_SAT_EN
        if (s[SW-1:DW-1] == '0 || s[SW-1:DW-1] == '1)
            r = s[DW-1:0];
        else
            r = s[SW-1] ? MINV : MAXV;
`else
        r = s[DW-1:0];
`endif
        return r;
    endfunction

    // Error, saturation and weight-update arithmetic on latched operands.
    always_comb begin
        e_full = {yc_q[DW-1], yc_q} - {yh_q[DW-1], yh_q};
        if (e_full[DW] != e_full[DW-1])
            e_sat = e_full[DW] ? MINV : MAXV;
        else
            e_sat = e_full[DW-1:0];
        e_abs    = e_q[DW] ? $unsigned(-e_q) : $unsigned(e_q);
        prod_a   = PW'(e_q) * PW'(x_q);
        prod_b   = PW'(e_q) * PW'(yl_q);
        sum_a    = SW'(a_q) + SW'(prod_a >>> MU_SHIFT);
        sum_b    = SW'(b_q) + SW'(prod_b >>> MU_SHIFT);
        iter_inc = iter_q + 8'd1;
    end

    // Next-state and register updates for the training sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        yl_d    = yl_q;
        yc_d    = yc_q;
        yh_d    = yh_q;
        e_d     = e_q;
        err_d   = err_q;
        a_d     = a_q;
        b_d     = b_q;
        iter_d  = iter_q;
        conv_d  = conv_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    iter_d  = '0;
                    err_d   = '0;
                    conv_d  = 1'b0;
                    state_d = WAIT_S;
                end
            end
            WAIT_S: begin
                if (s_valid) begin
                    x_d     = x_last;
                    yl_d    = y_last;
                    yc_d    = y_cur;
                    cnt_d   = '0;
                    state_d = FWD;
                end
            end
            FWD: begin
                if (cnt_q == CW'(FW_LAT)) begin
                    yh_d    = fw_y_hat;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERR: begin
                e_d     = e_full;
                err_d   = e_sat;
                state_d = UPD;
            end
            UPD: begin
                a_d    = narrow(sum_a);
                b_d    = narrow(sum_b);
                iter_d = iter_inc;
                if (e_abs <= (DW+1)'(ERR_TOL)) begin
                    conv_d  = 1'b1;
                    state_d = DONE;
                end else if (iter_inc == 8'(MAX_ITER)) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT_S;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            yl_q    <= '0;
            yc_q    <= '0;
            yh_q    <= '0;
            e_q     <= '0;
            err_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            iter_q  <= '0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            yl_q    <= yl_d;
            yc_q    <= yc_d;
            yh_q    <= yh_d;
            e_q     <= e_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
            iter_q  <= iter_d;
            conv_q  <= conv_d;
        end
    end

    assign s_ready   = (state_q == WAIT_S);
    assign fw_en     = (state_q == FWD) && (cnt_q == '0);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign a_hat     = a_q;
    assign b_hat     = b_q;
    assign err       = err_q;
    assign iter      = iter_q;
    assign converged = conv_q;

endmodule

// File: tb/tb_lms_train_ctrl.sv
// tb_lms_train_ctrl: directed vectors for lms_train_ctrl.
// Runs with FW_LAT=2, MAX_ITER=3, MU_SHIFT=4, DW=8.
module tb_lms_train_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic signed [7:0] x_last = '0;
    logic signed [7:0] y_last = '0;
    logic signed [7:0] y_cur = '0;
    logic signed [7:0] fw_y_hat = '0;
    logic fw_en;
    logic signed [7:0] a_hat, b_hat, err;
    logic [7:0] iter;
    logic busy, done, converged;

    int checks = 0;
    int errors = 0;
    int fw_cnt, done_cnt;
    logic signed [7:0] a_s4;

`ifdef LMS_WEIGHT_SAT_EN
    localparam int A3 = 127;
    localparam int B7 = 127;
`else
    localparam int A3 = -24;
    localparam int B7 = -8;
`endif

    typedef struct {
        int x, yl, yc, yh;
        int er, a, b, cv;
    } vec_t;
    vec_t tv[7];

    always #5 clk = ~clk;

    lms_train_ctrl #(
        .DW(8), .MU_SHIFT(4), .FW_LAT(2), .MAX_ITER(3), .ERR_TOL(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_ready(s_ready),
        .x_last(x_last), .y_last(y_last), .y_cur(y_cur),
        .fw_en(fw_en), .fw_y_hat(fw_y_hat),
        .a_hat(a_hat), .b_hat(b_hat), .err(err), .iter(iter),
        .busy(busy), .done(done), .converged(converged)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Accept one sample, then follow it five cycles to the weight update.
    task automatic run_sample(input int x, input int yl, input int yc,
                              input int yh, input bit poke);
        int n;
        n = 0;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            chk("accept_wait", 0, 1);
            return;
        end
        x_last = 8'(x);
        y_last = 8'(yl);
        y_cur = 8'(yc);
        fw_y_hat = 8'(yh);
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        fw_cnt = int'(fw_en);
        done_cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 1 && poke) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            fw_cnt += int'(fw_en);
            done_cnt += int'(done);
            if (k == 4) a_s4 = a_hat;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{2, 0, 16, 0, 16, 2, 0, 0};
        tv[1] = '{5, 3, 5, 5, 0, 0, 0, 1};
        tv[2] = '{127, 0, 127, -128, 127, A3, 0, 0};
        tv[3] = '{-4, 8, -20, 12, -32, 8, -16, 0};
        tv[4] = '{1, -1, -128, 127, -128, -16, 15, 0};
        tv[5] = '{1, 0, -1, 0, -1, -1, 0, 0};
        tv[6] = '{0, -128, -128, 127, -128, 0, B7, 0};

        repeat (2) @(negedge clk);
        chk("rst_a", a_hat, 0);
        chk("rst_b", b_hat, 0);
        chk("rst_err", err, 0);
        chk("rst_iter", iter, 0);
        chk("rst_flags", {fw_en, s_ready, busy, done, converged}, 0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_reset();
            do_start();
            run_sample(tv[i].x, tv[i].yl, tv[i].yc, tv[i].yh, 1'b0);
            chk($sformatf("v%0d_err", i), err, tv[i].er);
            chk($sformatf("v%0d_a", i), a_hat, tv[i].a);
            chk($sformatf("v%0d_b", i), b_hat, tv[i].b);
            chk($sformatf("v%0d_iter", i), iter, 1);
            chk($sformatf("v%0d_conv", i), converged, tv[i].cv);
            chk($sformatf("v%0d_done", i), done_cnt, tv[i].cv);
            chk($sformatf("v%0d_fw_en", i), fw_cnt, 1);
            chk($sformatf("v%0d_a_early", i), a_s4, 0);
            chk($sformatf("v%0d_ready", i), s_ready, tv[i].cv ? 0 : 1);
            @(negedge clk);
            chk($sformatf("v%0d_done_once", i), done, 0);
            chk($sformatf("v%0d_busy", i), busy, tv[i].cv ? 0 : 1);
        end

        do_reset();
        chk("idle_busy", busy, 0);
        chk("idle_ready", s_ready, 0);
        do_start();
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < 5; k++) begin
                if (!s_ready || fw_en || !busy) bad++;
                @(negedge clk);
            end
            chk("wait_hold", bad, 0);
        end

        run_sample(2, 0, 16, 0, 1'b0);
        chk("bud1_a", a_hat, 2);
        chk("bud1_iter", iter, 1);
        run_sample(2, 0, 16, 0, 1'b1);
        chk("bud2_a", a_hat, 4);
        chk("bud2_iter", iter, 2);
        chk("bud2_done", done_cnt, 0);
        run_sample(2, 0, 16, 0, 1'b0);
        chk("bud3_a", a_hat, 6);
        chk("bud3_done", done_cnt, 1);
        chk("bud3_conv", converged, 0);
        @(negedge clk);
        chk("bud_ready", s_ready, 0);
        chk("bud_busy", busy, 0);
        chk("bud_iter", iter, 3);
        chk("bud_conv_hold", converged, 0);

        do_start();
        chk("rerun_iter", iter, 0);
        chk("rerun_a", a_hat, 6);
        run_sample(1, 0, 16, 0, 1'b0);
        run_sample(1, 0, 16, 0, 1'b0);
        chk("mix_a", a_hat, 8);
        run_sample(1, 0, 3, 3, 1'b0);
        chk("mix_a_hold", a_hat, 8);
        chk("mix_iter", iter, 3);
        chk("mix_conv", converged, 1);
        chk("mix_done", done_cnt, 1);

        @(negedge clk);
        do_start();
        run_sample(1, 0, 16, 0, 1'b0);
        chk("pre_a", a_hat, 9);
        chk("pre_iter", iter, 1);
        x_last = 8'sd3;
        y_cur = 8'sd40;
        fw_y_hat = 8'sd0;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        chk("mid_fw_en", fw_en, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_a", a_hat, 0);
        chk("mid_b", b_hat, 0);
        chk("mid_err", err, 0);
        chk("mid_iter", iter, 0);
        chk("mid_flags", {fw_en, s_ready, busy, done, converged}, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_idle", {busy, s_ready}, 0);
        chk("post_a", a_hat, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
